// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four-requester round-robin arbiter feeding a registered 4:1 data mux
//    with a valid/ready output stage and a completed-transfer counter.
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    req[3:0]   per-requester request
//    din        requester i word at din[i*DATA_W +: DATA_W]
//    ack[3:0]   combinational pulse to the granted requester on a handshake
//    gnt[3:0]   registered one-hot grant, zero when idle
//    sel[1:0]   registered index of the granted requester
//    out_data   registered word captured at grant
//    out_valid  out_data holds an unaccepted word
//    out_ready  downstream accept
//    xfer_cnt   completed transfers, wraps modulo 256
module mux4_rr_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req,
   input  logic [4*DATA_W-1:0]   din,
   output logic [3:0]            ack,
   output logic [3:0]            gnt,
   output logic [1:0]            sel,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            xfer_cnt
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [1:0] ptr_q, ptr_d, sel_q, sel_d, base, win;
   logic [3:0] gnt_q, gnt_d, elig;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0] cnt_q, cnt_d;
   logic hs, found;
   assign hs = state_q == BUSY && out_ready;
   always_comb begin
      // On a handshake the search restarts just past the word leaving, and the
      // leaving requester is masked so a lone persistent requester yields an idle cycle.
      base = hs ? sel_q + 2'd1 : ptr_q;
      elig = hs ? req & ~gnt_q : (state_q == IDLE ? req : 4'b0);
      win = base;
      found = 1'b0;
      // Scanning from the farthest offset back toward base lets the closest hit win.
      for (int k = 3; k >= 0; k--) begin
         if (elig[base + 2'(k)]) begin
            win = base + 2'(k);
            found = 1'b1;
         end
      end
      state_d = state_q;
      sel_d = sel_q;
      gnt_d = gnt_q;
      data_d = data_q;
      ptr_d = base;
      cnt_d = cnt_q + {7'b0, hs};
      if (state_q == IDLE || hs) begin
         state_d = found ? BUSY : IDLE;
         gnt_d = found ? 4'b0001 << win : 4'b0;
         sel_d = found ? win : sel_q;
         data_d = found ? din[int'(win)*DATA_W +: DATA_W] : data_q;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= 2'd0;
         sel_q <= 2'd0;
         gnt_q <= 4'b0;
         data_q <= '0;
         cnt_q <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         sel_q <= sel_d;
         gnt_q <= gnt_d;
         data_q <= data_d;
         cnt_q <= cnt_d;
      end
   end
   assign ack = hs ? gnt_q : 4'b0;
   assign gnt = gnt_q;
   assign sel = sel_q;
   assign out_data = data_q;
   assign out_valid = state_q == BUSY;
   assign xfer_cnt = cnt_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: self-checking bench for mux4_rr_arbiter (vector table, directed
//    corner sequences, and a randomised scoreboard run).
module tb_mux4_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req = 4'b0;
   logic [31:0] din = 32'b0;
   logic out_ready = 1'b0;
   logic [3:0] ack, gnt;
   logic [1:0] sel;
   logic [7:0] out_data, xfer_cnt;
   logic out_valid;
   int errors = 0;
   int checks = 0;
   mux4_rr_arbiter #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .gnt(gnt), .sel(sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic rst; logic [3:0] req; logic [31:0] din; logic rdy;
      logic [3:0] gnt; logic [1:0] sel; logic [7:0] data; logic valid; logic [3:0] ack; logic [7:0] cnt;
   } vec_t;
   typedef struct { logic [1:0] sel; logic [7:0] data; } exp_t;
   vec_t vt [15];
   exp_t sb [$];
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0;
      out_ready = 1'b0;
      din = 32'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      bit mbusy;
      logic [1:0] mptr, msel;
      logic [7:0] mcnt;
      logic [3:0] elig;
      exp_t e;
      //          rst  req      din           rdy  gnt      sel   data   v     ack      cnt
      vt[0]  = '{1'b1, 4'b0000, 32'h44A52211, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 4'b0000, 8'd0};
      vt[1]  = '{1'b0, 4'b0000, 32'h44A52211, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 4'b0000, 8'd0};
      vt[2]  = '{1'b0, 4'b0100, 32'h44A52211, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 4'b0000, 8'd0};
      vt[3]  = '{1'b0, 4'b0000, 32'h44A52211, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 4'b0100, 8'd0};
      vt[4]  = '{1'b0, 4'b0000, 32'h44A52211, 1'b1, 4'b0000, 2'd2, 8'hA5, 1'b0, 4'b0000, 8'd1};
      vt[5]  = '{1'b1, 4'b1111, 32'h44332211, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 4'b0000, 8'd0};
      vt[6]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 4'b0000, 8'd0};
      vt[7]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 2'd0, 8'h11, 1'b1, 4'b0001, 8'd0};
      vt[8]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0010, 2'd1, 8'h22, 1'b1, 4'b0010, 8'd1};
      vt[9]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0100, 2'd2, 8'h33, 1'b1, 4'b0100, 8'd2};
      vt[10] = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b1000, 2'd3, 8'h44, 1'b1, 4'b1000, 8'd3};
      vt[11] = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 2'd0, 8'h11, 1'b1, 4'b0001, 8'd4};
      vt[12] = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0010, 2'd1, 8'h22, 1'b1, 4'b0010, 8'd5};
      vt[13] = '{1'b0, 4'b0000, 32'h44332211, 1'b1, 4'b0100, 2'd2, 8'h33, 1'b1, 4'b0100, 8'd6};
      vt[14] = '{1'b0, 4'b0000, 32'h44332211, 1'b1, 4'b0000, 2'd2, 8'h33, 1'b0, 4'b0000, 8'd7};
      tick();
      for (int i = 0; i < 15; i++) begin
         rst = vt[i].rst;
         req = vt[i].req;
         din = vt[i].din;
         out_ready = vt[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
         chk($sformatf("vec%0d sel", i), 32'(sel), 32'(vt[i].sel));
         chk($sformatf("vec%0d data", i), 32'(out_data), 32'(vt[i].data));
         chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vt[i].valid));
         chk($sformatf("vec%0d ack", i), 32'(ack), 32'(vt[i].ack));
         chk($sformatf("vec%0d cnt", i), 32'(xfer_cnt), 32'(vt[i].cnt));
         tick();
      end
      // backpressure: grant held and data frozen while out_ready is low
      do_reset();
      req = 4'b0011;
      din = 32'h00002010;
      tick();
      for (int i = 0; i < 5; i++) begin
         din[7:0] = 8'h30 + 8'(i);
         @(negedge clk);
         chk("bp gnt", 32'(gnt), 32'h1);
         chk("bp data", 32'(out_data), 32'h10);
         chk("bp ack", 32'(ack), 32'h0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release ack", 32'(ack), 32'h1);
      tick();
      @(negedge clk);
      chk("bp next gnt", 32'(gnt), 32'h2);
      chk("bp next data", 32'(out_data), 32'h20);
      // sole persistent requester alternates with idle cycles
      do_reset();
      req = 4'b1000;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("sole gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h8 : 32'h0);
         tick();
      end
      // reset while busy on requester 3
      do_reset();
      req = 4'b1000;
      din = 32'hC0000000;
      tick();
      @(negedge clk);
      chk("mid sel", 32'(sel), 32'h3);
      chk("mid valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("mid rst gnt", 32'(gnt), 32'h0);
      chk("mid rst sel", 32'(sel), 32'h0);
      chk("mid rst data", 32'(out_data), 32'h0);
      chk("mid rst valid", 32'(out_valid), 32'h0);
      chk("mid rst ack", 32'(ack), 32'h0);
      tick();
      rst = 1'b0;
      req = 4'b1111;
      tick();
      @(negedge clk);
      chk("post rst gnt", 32'(gnt), 32'h1);
      // counter wrap after 256 transfers
      do_reset();
      req = 4'b1111;
      out_ready = 1'b1;
      repeat (256) tick();
      @(negedge clk);
      chk("wrap cnt255", 32'(xfer_cnt), 32'd255);
      tick();
      @(negedge clk);
      chk("wrap cnt0", 32'(xfer_cnt), 32'd0);
      chk("wrap valid", 32'(out_valid), 32'h1);
      // randomised scoreboard run
      do_reset();
      sb.delete();
      mbusy = 1'b0;
      mptr = 2'd0;
      msel = 2'd0;
      mcnt = 8'd0;
      for (int c = 0; c < 400; c++) begin
         req = 4'($urandom_range(0, 15));
         din = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         chk("sb valid", 32'(out_valid), 32'(mbusy));
         chk("sb cnt", 32'(xfer_cnt), 32'(mcnt));
         if (mbusy && out_ready) begin
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL sb underflow: got handshake expected none");
            end else begin
               e = sb.pop_front();
               chk("sb data", 32'(out_data), 32'(e.data));
               chk("sb sel", 32'(sel), 32'(e.sel));
               chk("sb ack", 32'(ack), 32'(4'b0001 << e.sel));
            end
            mptr = msel + 2'd1;
            mcnt++;
            elig = req & ~(4'b0001 << msel);
         end else begin
            chk("sb no ack", 32'(ack), 32'h0);
            elig = mbusy ? 4'b0 : req;
         end
         if (!mbusy || out_ready) begin
            mbusy = 1'b0;
            for (int k = 0; k < 4; k++) begin
               int w;
               w = (int'(mptr) + k) % 4;
               if (!mbusy && elig[w]) begin
                  mbusy = 1'b1;
                  msel = 2'(w);
                  sb.push_back('{2'(w), din[w*8 +: 8]});
               end
            end
         end
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of each requester data word and of out_data.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request; bit i belongs to requester i.
REQ-005 The block SHALL have port din, input, 4*DATA_W bits: requester i data at bits [i*DATA_W +: DATA_W].
REQ-006 The block SHALL have port ack, output, 4 bits: one-cycle pulse to requester i when its word is accepted downstream.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot registered grant; all zeros when idle.
REQ-008 The block SHALL have port sel, output, 2 bits: registered index of the granted requester, the 4:1 select.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: registered word captured from the granted requester.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds an unaccepted word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data when out_valid=1 in the same cycle.
REQ-012 The block SHALL have port xfer_cnt, output, 8 bits: count of completed transfers, wrapping 255->0.

Function
REQ-013 The block SHALL implement two states: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 The block SHALL use rotating priority: search order starts at ptr and runs ptr, ptr+1, ... modulo 4. The first requester with an active eligible req wins.
REQ-015 In IDLE, when req has any bit set, the block SHALL do all of the following on the next edge, then enter BUSY:
- set gnt to one-hot of the winner;
- set sel to the winner index;
- capture out_data from din of the winner;
- set out_valid=1.
REQ-016 IDLE with req=0 SHALL remain IDLE, with gnt=0 and out_valid=0; sel and out_data SHALL hold their last values.
REQ-017 In BUSY without a handshake, the block SHALL hold gnt, sel, out_data and out_valid unchanged, whatever req and din do.
REQ-018 A handshake is out_valid=1 and out_ready=1 in the same cycle.
REQ-019 In a handshake cycle, ack SHALL equal gnt; this output is combinational. In all other cycles, ack SHALL be 0.
REQ-020 On the edge ending a handshake cycle:
- ptr SHALL become sel+1 modulo 4 (3 wraps to 0);
- xfer_cnt SHALL increment by 1, wrapping modulo 256.
REQ-021 In a handshake cycle, arbitration SHALL use the eligible vector req & ~gnt, where ptr is the updated value sel+1.
- If any eligible bit is set, the next grant and capture SHALL occur on the same edge and the state SHALL stay BUSY. There is no bubble.
- Otherwise the block SHALL go to IDLE and clear gnt.
REQ-022 A requester whose req drops during BUSY SHALL still complete its transfer, because its data was captured at grant.
REQ-023 A requester that keeps req high after its ack SHALL be re-eligible from the cycle after the handshake.
REQ-024 Throughput SHALL be one word per cycle when out_ready is held high and at least two requesters are active. Latency from req rising in IDLE to out_valid SHALL be 1 cycle.
REQ-025 out_ready while out_valid=0 SHALL be ignored: no ack pulse and no change to the counter.

Reset
REQ-026 While rst=1, independent of clk, the block SHALL force:
- state=IDLE and ptr=0;
- gnt=0, sel=0, out_data=0;
- out_valid=0, ack=0, xfer_cnt=0.
REQ-027 A reset asserted during BUSY SHALL discard the pending word with no ack. After rst falls, arbitration SHALL restart from ptr=0 on the first rising edge.

Verification
REQ-028 Single request:
- stimulus: DATA_W=8, out_ready=1, req=0100, din2=8'hA5;
- response: next cycle gnt=0100, sel=2, out_data=A5, out_valid=1; during that cycle ack=0100; the cycle after, out_valid=0 and xfer_cnt=1.
REQ-029 Fairness:
- stimulus: req=1111 held, out_ready=1 held, after reset;
- response: grants in the order 0,1,2,3,0,1 on consecutive cycles with no idle cycle; xfer_cnt reaches 6.
REQ-030 Backpressure:
- stimulus: req=0011, out_ready=0 for 5 cycles, din0 changing each cycle;
- response: gnt=0001 held and out_data equal to din0 at grant time; ack=0 throughout; when out_ready=1, ack=0001, then gnt=0010 on the next cycle.
REQ-031 Sole persistent requester:
- stimulus: req=1000 held, out_ready=1;
- response: gnt alternates 1000, 0000, 1000, 0000; the masked handshake cycle forces IDLE between grants.
REQ-032 Mid-transfer reset:
- stimulus: rst pulsed while BUSY with sel=3;
- response: all outputs zero immediately, with no ack; then req=1111 gives first grant gnt=0001.
REQ-033 Counter wrap:
- stimulus: 256 transfers;
- response: xfer_cnt returns to 0.
